reg_bank_wr: RTL

Parametrised CPU-side register bank written synchronously on the CPU clock under a write strobe and one-hot chip selects. It generalises the fixed three-register, 8-bit write block to NUM_REGS registers of DATA_W bits, adds a selectable level/edge write mode, a write lock, write acknowledge and error reporting, a saturating write counter and a registered read-back port. It sits between the CPU bus decode (which supplies `cs`) and the configuration registers consumed by downstream logic.

---
 rtl/reg_bank_wr_if.sv | 30 +++
 rtl/reg_bank_wr.sv | 94 +++++++++
 2 files changed

// File: rtl/reg_bank_wr_if.sv
// CPU-side bus bundle for the reg_bank_wr register bank: write strobe,
// chip selects, lock and read address in; register contents and status out.
interface reg_bank_wr_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 3,
    parameter int ADDR_W   = 2
);
    logic [DATA_W-1:0]          data_in;
    logic                       my_wr;
    logic [NUM_REGS-1:0]        cs;
    logic                       wr_lock;
    logic [ADDR_W-1:0]          rd_addr;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic [DATA_W-1:0]          rd_data;
    logic                       wr_ack;
    logic                       wr_err;
    logic [7:0]                 wr_cnt;

    // CPU bus decode side
    modport master (
        output data_in, my_wr, cs, wr_lock, rd_addr,
        input  regs, rd_data, wr_ack, wr_err, wr_cnt
    );

    // Register bank side
    modport slave (
        input  data_in, my_wr, cs, wr_lock, rd_addr,
        output regs, rd_data, wr_ack, wr_err, wr_cnt
    );
endinterface

// File: rtl/reg_bank_wr.sv
// Parametrised CPU register bank: one-hot chip-select writes with
// lowest-index priority, level or rising-edge write qualification, write
// lock, ack/error pulses, saturating accepted-write counter and a
// registered read-back port that returns pre-write (old) data.
module reg_bank_wr #(
    parameter int                             DATA_W    = 8,
    parameter int                             NUM_REGS  = 3,
    parameter int                             ADDR_W    = 2,
    parameter bit                             EDGE_MODE = 1'b0,
    parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    reg_bank_wr_if.slave  bus
);

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [DATA_W-1:0]   rd_data_r;
    logic                wr_ack_r;
    logic                wr_err_r;
    logic [7:0]          wr_cnt_r;
    // Resets high so a strobe already high at reset release is not an edge.
    logic                my_wr_d_r;

    logic                wq_s;
    logic                accept_s;
    logic                reject_s;
    logic [NUM_REGS-1:0] sel_s;
    logic [DATA_W-1:0]   rd_mux_s;

    // Write qualifier and accept/reject decision for this edge
    always_comb begin
        wq_s     = (EDGE_MODE != 1'b0) ? (bus.my_wr & ~my_wr_d_r) : bus.my_wr;
        accept_s = wq_s & ~bus.wr_lock & (bus.cs != '0);
        reject_s = wq_s & (bus.wr_lock | (bus.cs == '0));
    end

    // Lowest-index set chip select wins; the one-hot result drives the write
    always_comb begin
        logic found;
        found = 1'b0;
        sel_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_s[i] = bus.cs[i] & ~found;
            found    = found | bus.cs[i];
        end
    end

    // Read-back mux; addresses beyond the last register read as zero
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_mux_s = rd_mux_s | (regs_r[i] & {DATA_W{bus.rd_addr == ADDR_W'(i)}});
        end
    end

    // Register file, status pulses, counter and read-back register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
            rd_data_r <= '0;
            wr_ack_r  <= 1'b0;
            wr_err_r  <= 1'b0;
            wr_cnt_r  <= 8'd0;
            my_wr_d_r <= 1'b1;
        end else begin
            my_wr_d_r <= bus.my_wr;
            rd_data_r <= rd_mux_s;
            wr_ack_r  <= accept_s;
            wr_err_r  <= reject_s;
            if (accept_s && (wr_cnt_r != 8'hFF)) begin
                wr_cnt_r <= wr_cnt_r + 8'd1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (accept_s && sel_s[i]) begin
                    regs_r[i] <= bus.data_in;
                end
            end
        end
    end

    // Packed register contents straight from the flops
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign bus.regs[g*DATA_W +: DATA_W] = regs_r[g];
    end

    assign bus.rd_data = rd_data_r;
    assign bus.wr_ack  = wr_ack_r;
    assign bus.wr_err  = wr_err_r;
    assign bus.wr_cnt  = wr_cnt_r;

endmodule
